// File: rtl/bks16_seq_if.sv
// Request/response bundle for the sequential 16x16 carry-less multiplier.
// The requester drives start/a/b; the multiplier answers with busy/done/d.
interface bks16_seq_if;
    // start is honoured only while busy is low; a and b are captured on that edge.
    // done is a one-cycle pulse and d holds the result until the next done.
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [30:0] d;
    logic [1:0]  dbg_state;

    modport master (
        output start, a, b,
        input  busy, done, d, dbg_state
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, dbg_state
    );
endinterface

// File: rtl/bks16_seq.sv
// 16x16 GF(2)[x] multiplier: one top-level Karatsuba step spread over three
// cycles (low, high, folded middle) through a single shared 8x8 Karatsuba core.
module bks16_seq (
    input  logic       clk,
    input  logic       rst,
    bks16_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_MID  = 2'd3
    } state_t;

    function automatic logic [6:0] clmul4(input logic [3:0] x, input logic [3:0] y);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) r = r ^ ({3'b000, x} << i);
        end
        return r;
    endfunction

    // 8x8 core: one Karatsuba level over 4x4 schoolbook products.
    function automatic logic [14:0] bks8(input logic [7:0] x, input logic [7:0] y);
        logic [6:0] lo;
        logic [6:0] hi;
        logic [6:0] mid;
        lo  = clmul4(x[3:0], y[3:0]);
        hi  = clmul4(x[7:4], y[7:4]);
        mid = clmul4(x[7:4] ^ x[3:0], y[7:4] ^ y[3:0]);
        return {8'b0, lo} ^ {4'b0, lo ^ hi ^ mid, 4'b0} ^ {hi, 8'b0};
    endfunction

    state_t      r_state;
    logic [15:0] r_ra;
    logic [15:0] r_rb;
    logic [14:0] r_m1;
    logic [14:0] r_m2;
    logic [30:0] r_d;
    logic        r_done;

    logic [7:0]  w_op_a;
    logic [7:0]  w_op_b;
    logic [14:0] w_core;

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        case (r_state)
            S_LO: begin
                w_op_a = r_ra[7:0];
                w_op_b = r_rb[7:0];
            end
            S_HI: begin
                w_op_a = r_ra[15:8];
                w_op_b = r_rb[15:8];
            end
            S_MID: begin
                w_op_a = r_ra[15:8] ^ r_ra[7:0];
                w_op_b = r_rb[15:8] ^ r_rb[7:0];
            end
            default: begin
                w_op_a = '0;
                w_op_b = '0;
            end
        endcase
    end

    assign w_core = bks8(w_op_a, w_op_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_m1    <= '0;
            r_m2    <= '0;
            r_d     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ra    <= bus.a;
                        r_rb    <= bus.b;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    r_m2    <= w_core;
                    r_state <= S_HI;
                end
                S_HI: begin
                    r_m1    <= w_core;
                    r_state <= S_MID;
                end
                S_MID: begin
                    // Middle product is consumed straight from the core, never stored.
                    r_d     <= {16'b0, r_m2}
                             ^ {8'b0, r_m1 ^ r_m2 ^ w_core, 8'b0}
                             ^ {r_m1, 16'b0};
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.d         = r_d;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_bks16_seq.sv
// Bench for bks16_seq: directed carry-less products, back-to-back issue,
// reset abort and a short randomised run against a bitwise model.
module tb_bks16_seq;

    logic clk;
    logic rst;
    bks16_seq_if bus ();

    bks16_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_check;
    int n_pass;
    int n_fail;
    logic [30:0] exp_q[$];
    logic [30:0] last_d;
    logic        mon_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [30:0] clmul16(input logic [15:0] x, input logic [15:0] y);
        logic [30:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (y[i]) r = r ^ ({15'b0, x} << i);
        end
        return r;
    endfunction

    // Scoreboard monitor: pops on every done and checks d holds otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", {31'b0, bus.done}, 32'd0);
                end else begin
                    check("product", {1'b0, bus.d}, {1'b0, exp_q.pop_front()});
                end
                last_d = bus.d;
            end else if (rst) begin
                last_d = bus.d;
            end else begin
                check("d_hold", {1'b0, bus.d}, {1'b0, last_d});
            end
        end
    end

    // Issues one request from IDLE and checks busy/done timing edge by edge.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [30:0] exp);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            if (k == 0) begin
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
            end
            if (k == 2) bus.start = 1'b0;
            check("busy_timing", {31'b0, bus.busy}, {31'b0, (k < 3)});
            check("done_timing", {31'b0, bus.done}, {31'b0, (k == 3)});
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'b0, bus.done}, 32'd0);
    endtask

    logic [15:0] b2b_a[4];
    logic [15:0] b2b_b[4];
    logic [30:0] b2b_e[4];

    task automatic back_to_back();
        bus.a     = b2b_a[0];
        bus.b     = b2b_b[0];
        bus.start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(b2b_e[i]);
            #1;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            @(posedge clk);
            #1;
            check("b2b_busy", {31'b0, bus.busy}, 32'd1);
            @(posedge clk);
            @(posedge clk);
            #1;
            check("b2b_done", {31'b0, bus.done}, 32'd1);
            check("b2b_idle", {30'b0, bus.dbg_state}, 32'd0);
            if (i == 3) begin
                bus.start = 1'b0;
            end else begin
                bus.a = b2b_a[i + 1];
                bus.b = b2b_b[i + 1];
            end
            @(posedge clk);
        end
        #1;
        check("b2b_final_idle", {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic reset_mid_op();
        bus.a     = 16'h1234;
        bus.b     = 16'h5678;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_hi", {30'b0, bus.dbg_state}, 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_d", {1'b0, bus.d}, 32'd0);
        check("abort_state", {30'b0, bus.dbg_state}, 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", {31'b0, bus.done}, 32'd0);
        end
        do_op(16'h1234, 16'h5678, clmul16(16'h1234, 16'h5678));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_check   = 0;
        n_pass    = 0;
        n_fail    = 0;
        mon_en    = 1'b0;
        last_d    = '0;
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h5678;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_d", {1'b0, bus.d}, 32'd0);
        check("reset_state", {30'b0, bus.dbg_state}, 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("no_accept_after_reset", {31'b0, bus.busy}, 32'd0);
        last_d = '0;
        mon_en = 1'b1;

        do_op(16'h0003, 16'h0003, 31'h00000005);
        do_op(16'hFFFF, 16'h0001, 31'h0000FFFF);
        do_op(16'h8000, 16'h8000, 31'h40000000);
        do_op(16'h0101, 16'h0101, 31'h00010001);
        do_op(16'hFFFF, 16'hFFFF, 31'h55555555);
        do_op(16'h0000, 16'hABCD, 31'h00000000);
        do_op(16'hFF00, 16'h00FF, 31'h00555500);
        do_op(16'h0100, 16'h0001, 31'h00000100);

        b2b_a[0] = 16'h0003; b2b_b[0] = 16'h0003; b2b_e[0] = 31'h00000005;
        b2b_a[1] = 16'h00FF; b2b_b[1] = 16'h00FF; b2b_e[1] = 31'h00005555;
        b2b_a[2] = 16'hFF00; b2b_b[2] = 16'h00FF; b2b_e[2] = 31'h00555500;
        b2b_a[3] = 16'h8000; b2b_b[3] = 16'h0002; b2b_e[3] = 31'h00010000;
        back_to_back();

        reset_mid_op();

        for (int n = 0; n < 200; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_op(ra, rb, clmul16(ra, rb));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
